pe_layer_ctrl: RTL and testbench

PE_LAYER_CTRL -- requirements
Module: pe_layer_ctrl

---
 rtl/pe_layer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pe_layer_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_layer_ctrl.sv
// -----------------------------------------------------------------------------
// pe_layer_ctrl
//
// Purpose: sequences one layer pass of a processing-element (PE) datapath.
// For each neuron it fetches the weight vector and bias from memory, presents
// them to the PE together with the latched input activations, captures the PE
// result and writes it to the result memory. Each neuron takes 4 cycles:
// FETCH, LOAD, EVAL and WRITE. A one-cycle DONE state ends the pass.
//
// Optional feature: define PE_LAYER_CTRL_SAT_CNT_EN to add the sat_count
// output. It counts neurons whose PE result is 8'h7F during the current pass
// and saturates at 255.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a layer pass (sampled only in IDLE)
//   in_vec     62 x 8-bit activations, captured when start is accepted
//   w_rd_en    weight/bias memory read strobe (FETCH only)
//   w_addr     weight/bias memory address (current neuron index)
//   w_rdata    weight vector, valid one cycle after w_rd_en
//   b_rdata    sign-magnitude bias, valid with w_rdata
//   pe_bias    registered bias to the PE
//   pe_weight  registered weight vector to the PE
//   pe_in      registered activation vector to the PE
//   pe_out     PE result (combinational from the pe_* outputs)
//   res_we     result write strobe (WRITE only)
//   res_addr   result address (current neuron index)
//   res_data   captured PE result
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the DONE state
//   sat_count  (PE_LAYER_CTRL_SAT_CNT_EN only) count of saturated results
// -----------------------------------------------------------------------------
module pe_layer_ctrl #(
  parameter int NUM_NEURONS = 10,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [495:0]  in_vec,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [495:0]  w_rdata,
  input  logic [7:0]    b_rdata,
  output logic [7:0]    pe_bias,
  output logic [495:0]  pe_weight,
  output logic [495:0]  pe_in,
  input  logic [7:0]    pe_out,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [7:0]    res_data,
  output logic          busy,
  output logic          done
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
  ,
  output logic [7:0]    sat_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

  state_t        state;
  logic [AW-1:0] idx;

  // Both memories are addressed by the neuron index in every state, so the
  // addresses come straight from the index register.
  assign w_addr   = idx;
  assign res_addr = idx;

  // Strobes are registered: they are set on the edge that enters their state
  // and cleared by default on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      w_rd_en   <= 1'b0;
      res_we    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      pe_in     <= '0;
      pe_weight <= '0;
      pe_bias   <= '0;
      res_data  <= '0;
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
      sat_count <= '0;
`endif
    end else begin
      w_rd_en <= 1'b0;
      res_we  <= 1'b0;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            pe_in   <= in_vec;
            idx     <= '0;
            state   <= S_FETCH;
            w_rd_en <= 1'b1;
            busy    <= 1'b1;
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
            sat_count <= '0;
`endif
          end
        end

        // Memory read is in flight; data arrives during LOAD.
        S_FETCH: begin
          state <= S_LOAD;
        end

        S_LOAD: begin
          pe_weight <= w_rdata;
          pe_bias   <= b_rdata;
          state     <= S_EVAL;
        end

        // The PE result is combinational from pe_* which became valid at
        // the start of this cycle.
        S_EVAL: begin
          res_data <= pe_out;
          res_we   <= 1'b1;
          state    <= S_WRITE;
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
          if ((pe_out == 8'h7F) && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
          end
`endif
        end

        S_WRITE: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            idx     <= idx + AW'(1);
            state   <= S_FETCH;
            w_rd_en <= 1'b1;
          end
        end

        // start is not looked at here, so a request during DONE is dropped;
        // if it is still held it is taken on the following IDLE cycle.
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_layer_ctrl
//
// Randomized self-checking bench for pe_layer_ctrl. A 3-neuron instance runs
// a series of passes against a behavioural timeline model (4 cycles per
// neuron, DONE at 4*N+1). A 1-neuron instance covers the single-neuron case.
// The PE is modelled as a simple function of lane 0 of the activations and
// weights plus the bias magnitude. Build with PE_LAYER_CTRL_SAT_CNT_EN defined
// to also check sat_count.
// -----------------------------------------------------------------------------
module tb_pe_layer_ctrl;

  localparam int N = 3;

  typedef logic [495:0] wide_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [495:0]  in_vec;

  // 3-neuron instance
  logic          w_rd_en;
  logic [7:0]    w_addr;
  logic [495:0]  w_rdata;
  logic [7:0]    b_rdata;
  logic [7:0]    pe_bias;
  logic [495:0]  pe_weight;
  logic [495:0]  pe_in;
  logic [7:0]    pe_out;
  logic          res_we;
  logic [7:0]    res_addr;
  logic [7:0]    res_data;
  logic          busy;
  logic          done;

  // 1-neuron instance
  logic          start1;
  logic          w_rd_en1;
  logic [3:0]    w_addr1;
  logic [495:0]  w_rdata1;
  logic [7:0]    b_rdata1;
  logic [7:0]    pe_bias1;
  logic [495:0]  pe_weight1;
  logic [495:0]  pe_in1;
  logic [7:0]    pe_out1;
  logic          res_we1;
  logic [3:0]    res_addr1;
  logic [7:0]    res_data1;
  logic          busy1;
  logic          done1;

`ifdef PE_LAYER_CTRL_SAT_CNT_EN
  logic [7:0]    sat_count;
  logic [7:0]    sat_count1;
`endif

  // Weight/bias memory contents used by both instances
  logic [495:0]  wmem [0:3];
  logic [7:0]    bmem [0:3];

  // Model state: values the PE-facing registers must currently hold
  logic [495:0]  last_w;
  logic [7:0]    last_b;
  logic [7:0]    last_res;
  int            sat_exp;

  int            n_checks;
  int            n_fail;

  pe_layer_ctrl #(.NUM_NEURONS(N), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_vec    (in_vec),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .b_rdata   (b_rdata),
    .pe_bias   (pe_bias),
    .pe_weight (pe_weight),
    .pe_in     (pe_in),
    .pe_out    (pe_out),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done)
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  pe_layer_ctrl #(.NUM_NEURONS(1), .AW(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .in_vec    (in_vec),
    .w_rd_en   (w_rd_en1),
    .w_addr    (w_addr1),
    .w_rdata   (w_rdata1),
    .b_rdata   (b_rdata1),
    .pe_bias   (pe_bias1),
    .pe_weight (pe_weight1),
    .pe_in     (pe_in1),
    .pe_out    (pe_out1),
    .res_we    (res_we1),
    .res_addr  (res_addr1),
    .res_data  (res_data1),
    .busy      (busy1),
    .done      (done1)
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
    ,
    .sat_count (sat_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [495:0] rand_vec();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    return t[495:0];
  endfunction

  // Behavioural PE: 7-bit sum of activation lane 0, weight lane 0 and the
  // bias magnitude, giving a result in 0..127.
  function automatic logic [7:0] pe_func(input logic [495:0] a,
                                         input logic [495:0] w,
                                         input logic [7:0] b);
    logic [6:0] s;
    s = a[6:0] + w[6:0] + b[6:0];
    return {1'b0, s};
  endfunction

  assign pe_out  = pe_func(pe_in,  pe_weight,  pe_bias);
  assign pe_out1 = pe_func(pe_in1, pe_weight1, pe_bias1);

  // Registered-read memories; data is junk unless a read was strobed on the
  // previous edge, so a mistimed capture shows up.
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_rdata <= wmem[w_addr[1:0]];
      b_rdata <= bmem[w_addr[1:0]];
    end else begin
      w_rdata <= rand_vec();
      b_rdata <= 8'($urandom);
    end
    if (w_rd_en1) begin
      w_rdata1 <= wmem[w_addr1[1:0]];
      b_rdata1 <= bmem[w_addr1[1:0]];
    end else begin
      w_rdata1 <= rand_vec();
      b_rdata1 <= 8'($urandom);
    end
  end

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 4; i++) begin
      wmem[i] = rand_vec();
      bmem[i] = 8'($urandom);
    end
  endtask

  task automatic check_all_zero(input string ctx);
    check({ctx, " busy"},      wide_t'(busy),      '0);
    check({ctx, " w_rd_en"},   wide_t'(w_rd_en),   '0);
    check({ctx, " res_we"},    wide_t'(res_we),    '0);
    check({ctx, " done"},      wide_t'(done),      '0);
    check({ctx, " w_addr"},    wide_t'(w_addr),    '0);
    check({ctx, " res_addr"},  wide_t'(res_addr),  '0);
    check({ctx, " pe_in"},     pe_in,              '0);
    check({ctx, " pe_weight"}, pe_weight,          '0);
    check({ctx, " pe_bias"},   wide_t'(pe_bias),   '0);
    check({ctx, " res_data"},  wide_t'(res_data),  '0);
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
    check({ctx, " sat_count"}, wide_t'(sat_count), '0);
`endif
  endtask

  // One pass of the 3-neuron instance. repulse drives start at cycle 6 and
  // in the DONE cycle; rst_at (>0) asserts reset after checking that cycle.
  task automatic run_pass(input logic [495:0] vec, input bit repulse,
                          input int rst_at);
    int  k;
    int  ph;
    int  nw;
    int  nd;
    bit  is_done;
    in_vec = vec;
    start  = 1'b1;
    @(posedge clk); #2;
    sat_exp = 0;
    nw = 0;
    nd = 0;
    for (int c = 1; c <= 4*N + 1; c++) begin
      is_done = (c == 4*N + 1);
      k  = is_done ? N - 1 : (c - 1) / 4;
      ph = (c - 1) % 4;
      if (!is_done && ph == 2) begin
        last_w = wmem[k];
        last_b = bmem[k];
      end
      if (!is_done && ph == 3) begin
        last_res = pe_func(vec, wmem[k], bmem[k]);
        if (last_res == 8'h7F && sat_exp < 255) sat_exp++;
      end
      check("busy",      wide_t'(busy),     wide_t'(1'b1));
      check("w_rd_en",   wide_t'(w_rd_en),  wide_t'(!is_done && ph == 0));
      check("res_we",    wide_t'(res_we),   wide_t'(!is_done && ph == 3));
      check("done",      wide_t'(done),     wide_t'(is_done));
      check("w_addr",    wide_t'(w_addr),   wide_t'(k));
      check("res_addr",  wide_t'(res_addr), wide_t'(k));
      check("pe_in",     pe_in,             vec);
      check("pe_weight", pe_weight,         last_w);
      check("pe_bias",   wide_t'(pe_bias),  wide_t'(last_b));
      check("res_data",  wide_t'(res_data), wide_t'(last_res));
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
      check("sat_count", wide_t'(sat_count), wide_t'(sat_exp));
`endif
      if (res_we) begin
        nw++;
        $display("write addr=%0d data=%0h", res_addr, res_data);
      end
      if (done) nd++;
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1;
        $display("reset asserted at pass cycle %0d", c);
        check_all_zero("async rst");
        last_w   = '0;
        last_b   = '0;
        last_res = '0;
        sat_exp  = 0;
        start    = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (6) begin
          @(posedge clk); #2;
          check("post-rst res_we", wide_t'(res_we), '0);
          check("post-rst done",   wide_t'(done),   '0);
          check("post-rst busy",   wide_t'(busy),   '0);
        end
        return;
      end
      if (is_done) start = repulse ? 1'b1 : 1'($urandom_range(0, 1));
      else         start = repulse ? (c == 6) : 1'($urandom_range(0, 1));
      in_vec = rand_vec();
      @(posedge clk); #2;
    end
    // First IDLE cycle after DONE: any start seen in DONE must be dropped.
    check("idle busy",    wide_t'(busy),    '0);
    check("idle done",    wide_t'(done),    '0);
    check("idle w_rd_en", wide_t'(w_rd_en), '0);
    check("idle res_we",  wide_t'(res_we),  '0);
    check("idle pe_in",   pe_in,            vec);
    check("write count",  wide_t'(nw),      wide_t'(N));
    check("done count",   wide_t'(nd),      wide_t'(1));
    $display("pass complete writes=%0d dones=%0d", nw, nd);
    start = 1'b0;
    @(posedge clk); #2;
    check("idle2 busy", wide_t'(busy), '0);
  endtask

  initial begin
    logic [495:0] v;
    n_checks = 0;
    n_fail   = 0;
    last_w   = '0;
    last_b   = '0;
    last_res = '0;
    sat_exp  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    start1   = 1'b0;
    in_vec   = '0;
    randomize_mem();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    check("reset busy1", wide_t'(busy1), '0);
    rst = 1'b0;
    repeat (2) begin
      in_vec = rand_vec();
      @(posedge clk); #2;
      check("idle busy", wide_t'(busy), '0);
    end

    // Plain random pass
    randomize_mem();
    run_pass(rand_vec(), 1'b0, 0);

    // Known weight/bias for neuron 1
    randomize_mem();
    wmem[1] = {62{8'h11}};
    bmem[1] = 8'h83;
    run_pass(rand_vec(), 1'b0, 0);

    // start re-pulsed mid-pass and in the DONE cycle
    randomize_mem();
    run_pass(rand_vec(), 1'b1, 0);

    // Reset at cycle 7, then a fresh pass from neuron 0
    randomize_mem();
    run_pass(rand_vec(), 1'b0, 7);
    randomize_mem();
    run_pass(rand_vec(), 1'b0, 0);

    // PE results 7F, 10, 7F
    randomize_mem();
    v = rand_vec();
    v[7:0] = 8'h00;
    for (int i = 0; i < 3; i++) wmem[i][7:0] = 8'h00;
    bmem[0] = 8'h7F;
    bmem[1] = 8'h10;
    bmem[2] = 8'h7F;
    run_pass(v, 1'b0, 0);
`ifdef PE_LAYER_CTRL_SAT_CNT_EN
    check("sat_count after pass", wide_t'(sat_count), wide_t'(2));
`endif
    // Next pass must start its count from zero
    randomize_mem();
    run_pass(rand_vec(), 1'b0, 0);

    for (int p = 0; p < 6; p++) begin
      randomize_mem();
      run_pass(rand_vec(), 1'($urandom_range(0, 1)), 0);
    end

    // Single-neuron instance
    randomize_mem();
    v = rand_vec();
    in_vec = v;
    start1 = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("n1 w_rd_en",  wide_t'(w_rd_en1), wide_t'(c == 1));
      check("n1 res_we",   wide_t'(res_we1),  wide_t'(c == 4));
      check("n1 done",     wide_t'(done1),    wide_t'(c == 5));
      check("n1 busy",     wide_t'(busy1),    wide_t'(c <= 5));
      check("n1 w_addr",   wide_t'(w_addr1),  '0);
      check("n1 res_addr", wide_t'(res_addr1), '0);
      check("n1 pe_in",    pe_in1,            v);
      if (c == 4) begin
        check("n1 res_data", wide_t'(res_data1),
              wide_t'(pe_func(v, wmem[0], bmem[0])));
        $display("n1 write addr=%0d data=%0h", res_addr1, res_data1);
      end
      in_vec = rand_vec();
      @(posedge clk); #2;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
